// File: rtl/fetch_pc_unit_pkg.sv
// fetch_pc_unit_pkg: fetch FSM state encoding and PC constants shared by the fetch unit.
package fetch_pc_unit_pkg;
  localparam int REGWIDTH = 32;
  localparam logic [31:0] PCINC = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;
endpackage

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: owns the PC, issues single-outstanding fetches, hands instructions to decode
// and redirects on taken branches/jumps resolved in execute.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int XLEN = REGWIDTH,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic            ex_jump,
  input  logic            ex_zero,
  input  logic [XLEN-1:0] ex_target,
  output logic            redirect
);
  state_t state, next;
  logic [XLEN-1:0] pc;
  logic take;
  assign take = ex_valid && (ex_jump || (ex_branch && ex_zero));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end
  always_comb begin
    next = state;
    unique case (state)
      IDLE:    next = REQ;
      REQ:     next = take ? DRAIN : WAIT;
      WAIT:    next = imem_rvalid ? (take ? REQ : HOLD) : (take ? DRAIN : WAIT);
      HOLD:    next = (take || inst_ready) ? REQ : HOLD;
      DRAIN:   next = imem_rvalid ? REQ : DRAIN;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    imem_req  = state == REQ;
    imem_addr = imem_req ? pc : '0;
    redirect  = take && state != IDLE;
  end
  // a redirect in WAIT swallows the arriving response instead of presenting it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
    end else begin
      if (redirect) pc <= ex_target & ~XLEN'(3);
      else if (state == HOLD && inst_ready) pc <= pc + XLEN'(PCINC);
      if (state == WAIT && imem_rvalid && !redirect) begin
        inst       <= imem_rdata;
        inst_pc    <= pc;
        inst_valid <= 1'b1;
      end else if (state == HOLD && (inst_ready || redirect)) begin
        inst_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed scenarios with a transaction-level fetch model checked every cycle.
module tb_fetch_pc_unit;
  logic clk = 0, rst_n = 0;
  logic imem_req, inst_valid, redirect;
  logic [31:0] imem_addr, inst, inst_pc;
  logic imem_rvalid = 0, inst_ready = 0;
  logic ex_valid = 0, ex_branch = 0, ex_jump = 0, ex_zero = 0;
  logic [31:0] imem_rdata = 0, ex_target = 0;
  int checks = 0, errors = 0, cyc = 0;
  int lat = 1, mcnt = 0;
  logic [31:0] mem_word = 32'h0000_0013;

  fetch_pc_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .ex_valid(ex_valid),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_zero(ex_zero),
    .ex_target(ex_target), .redirect(redirect)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // memory: answers each request lat cycles after the request cycle, even across a reset
  initial forever begin
    @(posedge clk);
    #1;
    imem_rvalid = 0;
    if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) begin
        imem_rvalid = 1;
        imem_rdata = mem_word;
      end
    end
    @(negedge clk);
    if (imem_req) mcnt = lat;
  end

  // model: architectural pc, one outstanding fetch (possibly stale), one presented instruction
  logic [31:0] m_pc = 0, m_addr = 0, m_inst = 0, m_ipc = 0;
  bit m_idle = 1, m_out = 0, m_stale = 0, m_pres = 0;
  logic [31:0] q_addr[$];
  int q_cyc[$];

  always @(negedge clk) begin
    bit take, pres_n, out_n, stale_n;
    cyc++;
    if (!rst_n) begin
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_valid", inst_valid, 0);
      chk("rst_inst", inst, 0);
      chk("rst_pc", inst_pc, 0);
      chk("rst_redirect", redirect, 0);
      m_pc = 0; m_idle = 1; m_out = 0; m_stale = 0; m_pres = 0;
    end else if (m_idle) begin
      chk("idle_req", imem_req, 0);
      chk("idle_valid", inst_valid, 0);
      chk("idle_redirect", redirect, 0);
      m_idle = 0;
    end else begin
      take = ex_valid && (ex_jump || (ex_branch && ex_zero));
      chk("redirect", redirect, take);
      chk("req", imem_req, !m_out && !m_pres);
      if (imem_req) begin
        chk("addr", imem_addr, m_pc);
        q_addr.push_back(imem_addr);
        q_cyc.push_back(cyc);
      end
      chk("valid", inst_valid, m_pres);
      if (m_pres) begin
        chk("inst", inst, m_inst);
        chk("inst_pc", inst_pc, m_ipc);
      end
      pres_n = m_pres; out_n = m_out; stale_n = m_stale;
      if (imem_req) begin
        out_n = 1; stale_n = 0; m_addr = m_pc;
      end
      if (m_out && imem_rvalid) begin
        out_n = 0;
        if (!m_stale && !take) begin
          pres_n = 1; m_inst = imem_rdata; m_ipc = m_addr;
        end
      end
      if (m_pres && inst_ready && !take) begin
        pres_n = 0; m_pc = m_pc + 32'd4;
      end
      if (take) begin
        m_pc = ex_target & ~32'h3; pres_n = 0; stale_n = 1;
      end
      m_pres = pres_n; m_out = out_n; m_stale = stale_n;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  task automatic wait_req(output logic [31:0] a, output bit saw_valid);
    int n = 0;
    saw_valid = 0;
    do begin
      step();
      n++;
      if (inst_valid) saw_valid = 1;
    end while (!imem_req && n < 60);
    chk("req_timeout", imem_req, 1);
    a = imem_addr;
  endtask

  task automatic wait_valid(input bit any, input logic [31:0] pc);
    int n = 0;
    while (!(inst_valid && (any || inst_pc == pc)) && n < 80) begin
      step();
      n++;
    end
    chk("valid_timeout", inst_valid, 1);
  endtask

  initial begin
    logic [31:0] a;
    bit sv;
    inst_ready = 1;
    step();
    step();
    chk("lit_rst_req", imem_req, 0);
    chk("lit_rst_addr", imem_addr, 0);
    chk("lit_rst_valid", inst_valid, 0);
    chk("lit_rst_redirect", redirect, 0);
    rst_n = 1;
    step();
    chk("lit_first_req", imem_req, 1);
    chk("lit_first_addr", imem_addr, 32'h0);
    step();
    step();
    chk("lit_first_valid", inst_valid, 1);
    chk("lit_first_inst", inst, 32'h0000_0013);
    chk("lit_first_pc", inst_pc, 32'h0);
    repeat (7) step();
    chk("lit_qsize", q_addr.size() >= 3, 1);
    if (q_addr.size() >= 3) begin
      chk("lit_seq0", q_addr[0], 32'h0);
      chk("lit_seq1", q_addr[1], 32'h4);
      chk("lit_seq2", q_addr[2], 32'h8);
      chk("lit_gap01", q_cyc[1] - q_cyc[0], 3);
      chk("lit_gap12", q_cyc[2] - q_cyc[1], 3);
    end
    inst_ready = 0;
    mem_word = 32'h00A0_0093;
    wait_valid(1, 0);
    for (int i = 0; i < 5; i++) begin
      chk("lit_stall_inst", inst, 32'h00A0_0093);
      chk("lit_stall_pc", inst_pc, 32'hC);
      chk("lit_stall_valid", inst_valid, 1);
      chk("lit_stall_noreq", imem_req, 0);
      step();
    end
    inst_ready = 1;
    step();
    chk("lit_after_stall_req", imem_req, 1);
    chk("lit_after_stall_addr", imem_addr, 32'h10);
    mem_word = 32'h0000_0013;
    do_reset();
    wait_valid(0, 32'h8);
    ex_valid = 1; ex_branch = 1; ex_zero = 1; ex_target = 32'h40;
    #1 chk("lit_br_redirect", redirect, 1);
    step();
    ex_valid = 0; ex_branch = 0; ex_zero = 0;
    chk("lit_br_req", imem_req, 1);
    chk("lit_br_addr", imem_addr, 32'h40);
    do_reset();
    wait_valid(0, 32'h8);
    ex_valid = 1; ex_branch = 1; ex_zero = 0; ex_target = 32'h40;
    #1 chk("lit_nt_redirect", redirect, 0);
    step();
    ex_valid = 0; ex_branch = 0;
    chk("lit_nt_req", imem_req, 1);
    chk("lit_nt_addr", imem_addr, 32'hC);
    lat = 3;
    do_reset();
    wait_req(a, sv);
    chk("lit_j_first", a, 32'h0);
    step();
    ex_valid = 1; ex_jump = 1; ex_target = 32'h103;
    #1 chk("lit_j_redirect", redirect, 1);
    step();
    ex_valid = 0; ex_jump = 0;
    wait_req(a, sv);
    lat = 1;
    chk("lit_j_addr", a, 32'h100);
    chk("lit_j_no_stale", sv, 0);
    wait_valid(1, 0);
    ex_valid = 1; ex_jump = 1; ex_target = 32'hFFFF_FFFF;
    step();
    ex_valid = 0; ex_jump = 0;
    chk("lit_top_req", imem_req, 1);
    chk("lit_top_addr", imem_addr, 32'hFFFF_FFFC);
    wait_valid(0, 32'hFFFF_FFFC);
    wait_req(a, sv);
    chk("lit_wrap_addr", a, 32'h0);
    lat = 6;
    do_reset();
    wait_req(a, sv);
    step();
    step();
    rst_n = 0;
    #1;
    chk("lit_mid_rst_req", imem_req, 0);
    chk("lit_mid_rst_valid", inst_valid, 0);
    chk("lit_mid_rst_pc", inst_pc, 0);
    repeat (4) step();
    rst_n = 1;
    wait_req(a, sv);
    chk("lit_post_rst_addr", a, 32'h0);
    chk("lit_post_rst_no_stale", sv, 0);
    wait_valid(1, 0);
    chk("lit_post_rst_pc", inst_pc, 32'h0);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
